// File: rtl/fir0_pkg.sv
// Shared constants, coefficient tables and arithmetic helpers for the fir0 interpolate-by-2 filter.
// The optional FIR0_ROUND_EN macro (used in fir0_tap4) selects round-half-up scaling.
package fir0_pkg;

    localparam int N_IN   = 4;
    localparam int N_OUT  = 2 * N_IN;
    localparam int DIN_W  = 16;
    localparam int COEF_W = 16;
    localparam int PROD_W = DIN_W + COEF_W;
    localparam int ACC_W  = 34;
    localparam int DOUT_W = 18;
    localparam int LANE_W = 24;
    localparam int SHIFT  = 13;
    localparam int TAPS   = 4;
    localparam int HIST   = TAPS - 1;

    // Q14 coefficients on x[n-3 .. n], oldest first
    localparam logic signed [COEF_W-1:0] PH0_COEF [TAPS] = '{16'sd0, 16'sd16384, 16'sd0, 16'sd0};
    localparam logic signed [COEF_W-1:0] PH1_COEF [TAPS] = '{-16'sd1024, 16'sd9216, 16'sd9216, -16'sd1024};

    localparam logic signed [ACC_W-1:0]  SAT_HI_ACC = 34'sd131071;
    localparam logic signed [ACC_W-1:0]  SAT_LO_ACC = -34'sd131072;
    localparam logic signed [DOUT_W-1:0] SAT_HI     = {1'b0, {(DOUT_W-1){1'b1}}};
    localparam logic signed [DOUT_W-1:0] SAT_LO     = {1'b1, {(DOUT_W-1){1'b0}}};

    function automatic logic signed [COEF_W-1:0] coef_of(input int phase, input int k);
        logic signed [COEF_W-1:0] c;
        if (phase == 0) begin
            c = PH0_COEF[k];
        end else begin
            c = PH1_COEF[k];
        end
        return c;
    endfunction

    function automatic logic signed [DOUT_W-1:0] sat_dout(input logic signed [ACC_W-1:0] v);
        logic signed [DOUT_W-1:0] r;
        if (v > SAT_HI_ACC) begin
            r = SAT_HI;
        end else if (v < SAT_LO_ACC) begin
            r = SAT_LO;
        end else begin
            r = v[DOUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fir0_interp2_if.sv
// AXI-Stream style input (4 complex lanes) and output (8 complex lanes) bundle for fir0_interp2.
interface fir0_interp2_if;
    import fir0_pkg::*;

    logic                         s_axis_data_tvalid;
    logic                         s_axis_data_tready;
    logic [N_IN*2*DIN_W-1:0]      s_axis_data_tdata;
    logic                         m_axis_data_tvalid;
    logic [N_OUT*2*LANE_W-1:0]    m_axis_data_tdata;

    modport slave (
        input  s_axis_data_tvalid,
        input  s_axis_data_tdata,
        output s_axis_data_tready,
        output m_axis_data_tvalid,
        output m_axis_data_tdata
    );

    modport master (
        output s_axis_data_tvalid,
        output s_axis_data_tdata,
        input  s_axis_data_tready,
        input  m_axis_data_tvalid,
        input  m_axis_data_tdata
    );

endinterface

// File: rtl/fir0_tap4.sv
// 4-tap MAC for one real component and one phase: registered products, then sum, >>13 scale
// and saturate into the output register. FIR0_ROUND_EN adds 2^12 before the shift (round-half-up).
module fir0_tap4
    import fir0_pkg::*;
#(
    parameter int PHASE = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     prod_en_i,
    input  logic                     sum_en_i,
    input  logic [TAPS*DIN_W-1:0]    x_i,
    output logic signed [DOUT_W-1:0] y_o
);

`ifdef FIR0_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND = 34'sd4096;
`else
    localparam logic signed [ACC_W-1:0] RND = 34'sd0;
`endif

    logic signed [PROD_W-1:0] prod_d [TAPS];
    logic signed [PROD_W-1:0] prod_q [TAPS];
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [DOUT_W-1:0] y_d;
    logic signed [DOUT_W-1:0] y_q;

    // Products of each window sample with its phase coefficient
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            prod_d[k] = $signed(x_i[k*DIN_W +: DIN_W]) * coef_of(PHASE, k);
        end
    end

    // Product register, advanced only when a valid beat sits in the window stage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < TAPS; k++) begin
                prod_q[k] <= '0;
            end
        end else if (prod_en_i) begin
            for (int k = 0; k < TAPS; k++) begin
                prod_q[k] <= prod_d[k];
            end
        end
    end

    // Full-precision sum with the rounding offset folded in, then scale and clamp
    always_comb begin
        acc_d = RND;
        for (int k = 0; k < TAPS; k++) begin
            acc_d = acc_d + ACC_W'(prod_q[k]);
        end
        y_d = sat_dout(acc_d >>> SHIFT);
    end

    // Output register holds its value between valid beats
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            y_q <= '0;
        end else if (sum_en_i) begin
            y_q <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/fir0_interp2.sv
// Complex interpolate-by-2 polyphase FIR, 4 samples in / 8 out per clock, 3-cycle latency.
// Build option FIR0_ROUND_EN selects round-half-up instead of floor scaling.
module fir0_interp2
    import fir0_pkg::*;
(
    input  logic          aclk,
    input  logic          aresetn,
    fir0_interp2_if.slave bus
);

    localparam int WIN_W = (HIST + N_IN) * DIN_W;

    logic                      tready_q;
    logic                      v1_q;
    logic                      v2_q;
    logic                      v3_q;
    logic                      accept_s;
    logic [N_IN*DIN_W-1:0]     re_s;
    logic [N_IN*DIN_W-1:0]     im_s;
    logic [HIST*DIN_W-1:0]     hist_re_q;
    logic [HIST*DIN_W-1:0]     hist_im_q;
    logic [WIN_W-1:0]          win_re_q;
    logic [WIN_W-1:0]          win_im_q;
    logic signed [DOUT_W-1:0]  y_re_s [N_OUT];
    logic signed [DOUT_W-1:0]  y_im_s [N_OUT];
    logic [N_OUT*2*LANE_W-1:0] tdata_s;

    assign accept_s = bus.s_axis_data_tvalid & tready_q;

    // Split the input beat into packed real and imaginary lane vectors
    always_comb begin
        re_s = '0;
        im_s = '0;
        for (int i = 0; i < N_IN; i++) begin
            re_s[i*DIN_W +: DIN_W] = bus.s_axis_data_tdata[2*DIN_W*i +: DIN_W];
            im_s[i*DIN_W +: DIN_W] = bus.s_axis_data_tdata[2*DIN_W*i + DIN_W +: DIN_W];
        end
    end

    // Handshake, valid pipeline and the 7-sample window (3 history + current beat, oldest in LSBs)
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tready_q  <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            hist_re_q <= '0;
            hist_im_q <= '0;
            win_re_q  <= '0;
            win_im_q  <= '0;
        end else begin
            tready_q <= 1'b1;
            v1_q     <= accept_s;
            v2_q     <= v1_q;
            v3_q     <= v2_q;
            if (accept_s) begin
                win_re_q  <= {re_s, hist_re_q};
                win_im_q  <= {im_s, hist_im_q};
                hist_re_q <= re_s[N_IN*DIN_W-1 -: HIST*DIN_W];
                hist_im_q <= im_s[N_IN*DIN_W-1 -: HIST*DIN_W];
            end
        end
    end

    // Lane i sees x[n-3 .. n] at window offset i; phase 0 is even output, phase 1 odd
    for (genvar i = 0; i < N_IN; i++) begin : g_lane
        for (genvar ph = 0; ph < 2; ph++) begin : g_phase
            fir0_tap4 #(.PHASE(ph)) u_re (
                .clk_i     (aclk),
                .rst_ni    (aresetn),
                .prod_en_i (v1_q),
                .sum_en_i  (v2_q),
                .x_i       (win_re_q[i*DIN_W +: TAPS*DIN_W]),
                .y_o       (y_re_s[2*i+ph])
            );
            fir0_tap4 #(.PHASE(ph)) u_im (
                .clk_i     (aclk),
                .rst_ni    (aresetn),
                .prod_en_i (v1_q),
                .sum_en_i  (v2_q),
                .x_i       (win_im_q[i*DIN_W +: TAPS*DIN_W]),
                .y_o       (y_im_s[2*i+ph])
            );
        end
    end

    // Sign-extend each 18-bit result into its 24-bit lane slot
    always_comb begin
        tdata_s = '0;
        for (int j = 0; j < N_OUT; j++) begin
            tdata_s[2*LANE_W*j +: LANE_W]          = LANE_W'(y_re_s[j]);
            tdata_s[2*LANE_W*j + LANE_W +: LANE_W] = LANE_W'(y_im_s[j]);
        end
    end

    assign bus.s_axis_data_tready = tready_q;
    assign bus.m_axis_data_tvalid = v3_q;
    assign bus.m_axis_data_tdata  = tdata_s;

endmodule

// File: tb/tb_fir0_interp2.sv
// Scoreboard bench for fir0_interp2: expected beats are derived from the filter equations on accept.
module tb_fir0_interp2;
    import fir0_pkg::*;

    localparam real AMP = 26214.4;
    localparam real W   = 0.0628;
    localparam logic [127:0] DC_BEAT = 128'h0000_4000_0000_4000_0000_4000_0000_4000;

    logic aclk = 1'b0;
    logic aresetn;
    int   errors = 0;
    int   checks = 0;

    logic [383:0] exp_q [$];
    logic [383:0] rx_q  [$];
    logic [383:0] od_log [$];
    logic         ov_log [$];
    logic         rdy_log [$];
    int           hist_re [3];
    int           hist_im [3];

    fir0_interp2_if bus ();

    fir0_interp2 dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus.slave)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (bus.m_axis_data_tvalid === 1'b1) rx_q.push_back(bus.m_axis_data_tdata);
    end

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    function automatic int lane_in(input logic [127:0] d, input int i, input int c);
        return int'($signed(d[32*i + 16*c +: 16]));
    endfunction

    // y[2n] = x[n-2]; y[2n+1] = (-x[n-3] + 9x[n-2] + 9x[n-1] - x[n]) / 16; output carries 2*y
    task automatic model_push(input logic [127:0] d);
        int w [7];
        int s;
        int y;
        logic [383:0] e;
        e = '0;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 3; k++) w[k] = (c == 0) ? hist_re[k] : hist_im[k];
            for (int i = 0; i < 4; i++) w[3+i] = lane_in(d, i, c);
            for (int i = 0; i < 4; i++) begin
                for (int ph = 0; ph < 2; ph++) begin
                    if (ph == 0) begin
                        y = 2 * w[i+1];
                    end else begin
                        s = -w[i] + 9*w[i+1] + 9*w[i+2] - w[i+3];
`ifdef FIR0_ROUND_EN
                        y = (s + 4) >>> 3;
`else
                        y = s >>> 3;
`endif
                    end
                    if (y > 131071) y = 131071;
                    if (y < -131072) y = -131072;
                    e[48*(2*i+ph) + 24*c +: 24] = 24'(y);
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (c == 0) hist_re[k] = w[4+k];
                else        hist_im[k] = w[4+k];
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic clear_state();
        exp_q.delete(); rx_q.delete(); od_log.delete(); ov_log.delete(); rdy_log.delete();
        for (int k = 0; k < 3; k++) begin hist_re[k] = 0; hist_im[k] = 0; end
    endtask

    task automatic step(input logic v, input logic [127:0] d);
        bus.s_axis_data_tvalid = v;
        bus.s_axis_data_tdata  = d;
        @(negedge aclk);
        ov_log.push_back(bus.m_axis_data_tvalid);
        od_log.push_back(bus.m_axis_data_tdata);
        rdy_log.push_back(bus.s_axis_data_tready);
        if (v && bus.s_axis_data_tready) model_push(d);
        @(posedge aclk); #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        bus.s_axis_data_tvalid = 1'b0;
        bus.s_axis_data_tdata  = '0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        clear_state();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        bus.s_axis_data_tvalid = 1'b0;
        bus.s_axis_data_tdata  = '0;
        @(posedge aclk); @(negedge aclk);
        checks++;
        if (bus.s_axis_data_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b expected 0", bus.s_axis_data_tready); end
        checks++;
        if (bus.m_axis_data_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", bus.m_axis_data_tvalid); end
        checks++;
        if (bus.m_axis_data_tdata !== 384'd0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", bus.m_axis_data_tdata); end
        do_reset();
        for (int k = 0; k < 6; k++) step(1'b0, '0);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (rdy_log[k] !== 1'b1 || ov_log[k] !== 1'b0)
                begin errors++; $display("FAIL idle_cycle %0d: got tready=%b tvalid=%b expected tready=1 tvalid=0", k, rdy_log[k], ov_log[k]); end
        end
    endtask

    task automatic test_latency();
        logic [383:0] got, want;
        do_reset();
        step(1'b1, {$urandom(), $urandom(), $urandom(), $urandom()});
        for (int k = 0; k < 6; k++) step(1'b0, '0);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (ov_log[k] !== (k == 3))
                begin errors++; $display("FAIL latency_valid cycle %0d: got %b expected %b", k, ov_log[k], (k == 3)); end
        end
        checks++;
        if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL latency_count: got %0d beats expected %0d", rx_q.size(), exp_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("FAIL latency_data: got %h expected %h", got, want); end
        end
    endtask

    task automatic test_dc();
        logic [383:0] got, want;
        int b;
        do_reset();
        for (int k = 0; k < 8; k++) step(1'b1, DC_BEAT);
        for (int k = 0; k < 5; k++) step(1'b0, '0);
        checks++;
        if (rx_q.size() != 8) begin errors++; $display("FAIL dc_count: got %0d beats expected 8", rx_q.size()); end
        b = 0;
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("FAIL dc_data beat %0d: got %h expected %h", b, got, want); end
            if (b >= 1) begin
                for (int j = 0; j < 8; j++) begin
                    checks++;
                    if (int'($signed(got[48*j +: 18])) != 32768 || int'($signed(got[48*j+24 +: 18])) != 0)
                        begin errors++; $display("FAIL dc_level beat %0d lane %0d: got re=%0d im=%0d expected re=32768 im=0", b, j, int'($signed(got[48*j +: 18])), int'($signed(got[48*j+24 +: 18]))); end
                end
            end
            b++;
        end
    endtask

    task automatic test_impulse();
        logic [383:0] got, want;
`ifdef FIR0_ROUND_EN
        int imp [8] = '{0, 0, 0, 1, 2, 1, 0, 0};
`else
        int imp [8] = '{0, -1, 0, 1, 2, 1, 0, -1};
`endif
        do_reset();
        step(1'b1, 128'd1);
        step(1'b1, '0);
        step(1'b1, '0);
        for (int k = 0; k < 5; k++) step(1'b0, '0);
        checks++;
        if (rx_q.size() != 3) begin errors++; $display("FAIL impulse_count: got %0d beats expected 3", rx_q.size()); end
        if (rx_q.size() > 0) begin
            got = rx_q[0];
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (int'($signed(got[48*j +: 24])) != imp[j] || int'($signed(got[48*j+24 +: 24])) != 0)
                    begin errors++; $display("FAIL impulse_y%0d: got re=%0d im=%0d expected re=%0d im=0", j, int'($signed(got[48*j +: 24])), int'($signed(got[48*j+24 +: 24])), imp[j]); end
            end
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("FAIL impulse_data: got %h expected %h", got, want); end
        end
    endtask

    task automatic test_sine();
        logic [383:0] got, want;
        logic [127:0] d;
        int  b, bad, n;
        real t, dr, di;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 4; i++) begin
                n = 4*c + i;
                d[32*i +: 16]    = 16'(rnd(AMP * $cos(W * n)));
                d[32*i+16 +: 16] = 16'(rnd(AMP * $sin(W * n)));
            end
            step(1'b1, d);
        end
        for (int k = 0; k < 5; k++) step(1'b0, '0);
        checks++;
        if (rx_q.size() != 16) begin errors++; $display("FAIL sine_count: got %0d beats expected 16", rx_q.size()); end
        b = 0;
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("FAIL sine_data beat %0d: got %h expected %h", b, got, want); end
            if (b >= 1) begin
                bad = 0;
                for (int j = 0; j < 8; j++) begin
                    t  = real'(8*b + j) / 2.0 - 2.0;
                    dr = real'(int'($signed(got[48*j+1 +: 16])))  - AMP * $cos(W * t);
                    di = real'(int'($signed(got[48*j+25 +: 16]))) - AMP * $sin(W * t);
                    if (dr > 64.0 || dr < -64.0 || di > 64.0 || di < -64.0) bad++;
                end
                checks++;
                if (bad != 0) begin errors++; $display("FAIL sine_track beat %0d: got %0d lanes beyond 64 LSB expected 0", b, bad); end
            end
            b++;
        end
    endtask

    task automatic test_toggle();
        logic [383:0] got, want;
        logic exp_v;
        int b;
        do_reset();
        for (int k = 0; k < 16; k++) step((k % 2) == 0, DC_BEAT);
        for (int k = 0; k < 5; k++) step(1'b0, '0);
        for (int k = 3; k < 21; k++) begin
            exp_v = (k - 3 < 16) && ((k - 3) % 2 == 0);
            checks++;
            if (ov_log[k] !== exp_v) begin errors++; $display("FAIL toggle_valid cycle %0d: got %b expected %b", k, ov_log[k], exp_v); end
            if (!exp_v && k > 3) begin
                checks++;
                if (od_log[k] !== od_log[k-1]) begin errors++; $display("FAIL toggle_hold cycle %0d: got %h expected %h", k, od_log[k], od_log[k-1]); end
            end
        end
        checks++;
        if (rx_q.size() != 8) begin errors++; $display("FAIL toggle_count: got %0d beats expected 8", rx_q.size()); end
        b = 0;
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("FAIL toggle_data beat %0d: got %h expected %h", b, got, want); end
            if (b >= 1) begin
                checks++;
                if (int'($signed(got[48*7 +: 18])) != 32768) begin errors++; $display("FAIL toggle_level beat %0d: got %0d expected 32768", b, int'($signed(got[48*7 +: 18]))); end
            end
            b++;
        end
    endtask

    task automatic test_midreset();
        logic [383:0] got, want;
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, DC_BEAT);
        bus.s_axis_data_tvalid = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (bus.m_axis_data_tvalid !== 1'b0 || bus.m_axis_data_tdata !== 384'd0 || bus.s_axis_data_tready !== 1'b0)
            begin errors++; $display("FAIL midreset_async: got tvalid=%b tready=%b tdata=%h expected all 0", bus.m_axis_data_tvalid, bus.s_axis_data_tready, bus.m_axis_data_tdata); end
        checks++;
        if (rx_q.size() != 2) begin errors++; $display("FAIL midreset_pre_count: got %0d beats expected 2", rx_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("FAIL midreset_pre_data: got %h expected %h", got, want); end
        end
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        clear_state();
        step(1'b1, DC_BEAT);
        for (int k = 0; k < 5; k++) step(1'b0, '0);
        checks++;
        if (rx_q.size() != 1) begin errors++; $display("FAIL midreset_post_count: got %0d beats expected 1", rx_q.size()); end
        if (rx_q.size() > 0) begin
            got = rx_q[0];
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (int'($signed(got[96*i +: 18])) != ((i < 2) ? 0 : 32768))
                    begin errors++; $display("FAIL midreset_even lane %0d: got %0d expected %0d", 2*i, int'($signed(got[96*i +: 18])), (i < 2) ? 0 : 32768); end
            end
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); want = exp_q.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("FAIL midreset_post_data: got %h expected %h", got, want); end
        end
    endtask

    initial begin
        aresetn = 1'b0;
        bus.s_axis_data_tvalid = 1'b0;
        bus.s_axis_data_tdata  = '0;
        test_reset();
        test_latency();
        test_dc();
        test_impulse();
        test_sine();
        test_toggle();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
